lsp_pipe_arbiter: RTL and testbench
===================================

LSP_PIPE_ARBITER -- requirements
Module: lsp_pipe_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_REQ, 4, number of requester FSMs sharing the L_mult/add/L_mac pipe and scratch memory port.
  DRAIN_CYCLES, 2, idle cycles after release so in-flight pipe results retire.
  MAX_HOLD, 1023, maximum consecutive owned cycles before forced release.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock, all logic on rising edge.
  reset  input  1  synchronous, active-high reset.
  req  input  NUM_REQ  per-requester request; held high for the whole transaction, dropped to release.
  testMode  input  1  test-port ownership request (drives the Mux0Sel..Mux3Sel test path).
  grant  output  NUM_REQ  one-hot grant, registered.
  ownerSel  output  3  registered select for the pipe muxes: 0..3 = requester index, 4 = test, 7 = none.
  busy  output  1  high in any state except IDLE.
  timeout  output  1  sticky: set on forced release, cleared only by reset.

Function
REQ-003 The FSM SHALL have states IDLE, OWN, TEST and DRAIN.
REQ-004 In IDLE with testMode=1, the FSM SHALL enter TEST next cycle; testMode wins over any req.
REQ-005 In IDLE with testMode=0 and any req bit high, the FSM SHALL pick a winner round-robin and enter OWN next cycle; grant and ownerSel change on that same edge (1-cycle latency).
REQ-006 Round-robin priority SHALL start at the index after the last granted requester, wrapping NUM_REQ-1 to 0; after reset requester 0 has highest priority.
REQ-007 In OWN, grant SHALL stay constant while the owner's req is high; other req changes and testMode SHALL NOT preempt.
REQ-008 When the owner's req is sampled low at edge t, grant SHALL be all-zero and the state DRAIN from t+1. After DRAIN_CYCLES DRAIN cycles the state SHALL be IDLE, so with DRAIN_CYCLES=2 the earliest next grant is at t+4 (grant low for 3 cycles).
REQ-009 A hold counter SHALL load 1 on entry to OWN and increment each OWN cycle. If it equals MAX_HOLD while the owner's req is still high, the FSM SHALL enter DRAIN next cycle, set timeout, and advance the round-robin pointer past the owner.
REQ-010 TEST SHALL hold ownerSel=4 and grant=0 until testMode is sampled low, then enter DRAIN. TEST has no timeout.
REQ-011 In DRAIN, req and testMode SHALL be ignored. The drain counter SHALL count DRAIN_CYCLES cycles, then move to IDLE.
REQ-012 ownerSel SHALL be 7 in IDLE and DRAIN. grant SHALL be one-hot in OWN and zero in all other states.
REQ-013 A requester whose req is high while another requester owns the pipe SHALL simply wait; no request is lost or queued beyond the current level of req.
REQ-014 Counter widths SHALL be ceil(log2(MAX_HOLD+1)) for the hold counter and ceil(log2(DRAIN_CYCLES+1)) for the drain counter, and neither counter SHALL wrap.

Reset
REQ-015 Reset SHALL force state=IDLE, grant=0, ownerSel=7, busy=0, timeout=0, hold/drain counters=0 and round-robin pointer=last-granted NUM_REQ-1, so requester 0 is first.
REQ-016 Reset asserted mid-OWN or mid-TEST SHALL drop grant to zero on the next edge. It SHALL NOT go through DRAIN.

Structure
REQ-017 A shared package lsp_arb_pkg SHALL hold the state encoding, the ownerSel codes (OWNER_TEST=4, OWNER_NONE=7) and the default parameter values.
REQ-018 The combinational round-robin pick (req vector plus pointer to one-hot winner plus index) SHALL be a single sub-module lsp_rr_select. All registers live in lsp_pipe_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
  Single requester: req=4'b0010 at cycle 0 -> grant=0010 and ownerSel=1 at cycle 1. Drop req at cycle 5 -> grant=0 at cycle 6, busy=0 at cycle 8.
  Fairness: req=4'b1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0 with a 3-cycle gap between grants.
  Timeout: MAX_HOLD=8, req[2] held forever with req[3] also high -> grant[2] for exactly 8 cycles, timeout=1, then DRAIN, then grant[3]. timeout stays 1.
  Test priority: testMode=1 and req=4'b0001 together in IDLE -> ownerSel=4, grant=0. Drop testMode -> DRAIN for 2 cycles -> grant=0001.
  No preemption: testMode raised while requester 1 owns -> ownerSel stays 1 until release, then DRAIN, then TEST.
  Reset mid-OWN: reset during grant=0100 -> next edge grant=0, ownerSel=7. After release of reset with req=4'b0101 -> grant=0001.

Source files
------------

// File: rtl/lsp_arb_pkg.sv
// Shared encodings and defaults for the LSP pipe arbiter.
// Holds FSM state codes, ownerSel codes and the counter width helper.
package lsp_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_DRAIN_CYCLES = 2;
  localparam int unsigned DEF_MAX_HOLD     = 1023;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_TEST  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int unsigned OWNER_W = 3;
  typedef logic [OWNER_W-1:0] owner_sel_t;

  localparam owner_sel_t OWNER_TEST = 3'd4;
  localparam owner_sel_t OWNER_NONE = 3'd7;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lsp_rr_select.sv
// Combinational round-robin pick: the first requester after last_idx wins.
// Produces the winner as a one-hot vector and as an index.
module lsp_rr_select
  import lsp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // Scan from last_idx+1 around to last_idx itself; the first hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      int unsigned cand;
      cand = (32'(last_idx) + off) % NUM_REQ;
      if (!gnt_valid && req[IDX_W'(cand)]) begin
        gnt_valid                   = 1'b1;
        gnt_idx                     = IDX_W'(cand);
        gnt_onehot[IDX_W'(cand)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsp_pipe_arbiter.sv
// Arbiter for the shared L_mult/add/L_mac pipe and scratch port among the LSP
// requester FSMs, with a test-port owner, bounded hold time and a drain gap.
module lsp_pipe_arbiter
  import lsp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned MAX_HOLD     = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               testMode,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         ownerSel,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W  = cnt_width(MAX_HOLD);
  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_CYCLES);

  logic [1:0]         state_q,     state_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  owner_sel_t         owner_sel_q, owner_sel_d;
  logic               busy_q,      busy_d;
  logic               timeout_q,   timeout_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [IDX_W-1:0]   last_idx_q,  last_idx_d;
  logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;

  logic [NUM_REQ-1:0] rr_onehot_c;
  logic [IDX_W-1:0]   rr_idx_c;
  logic               rr_valid_c;
  logic               owner_req_c;

  lsp_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_idx   (last_idx_q),
    .gnt_onehot (rr_onehot_c),
    .gnt_idx    (rr_idx_c),
    .gnt_valid  (rr_valid_c)
  );

  assign owner_req_c = req[owner_idx_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_sel_d = owner_sel_q;
    timeout_d   = timeout_q;
    hold_cnt_d  = hold_cnt_q;
    drain_cnt_d = drain_cnt_q;
    last_idx_d  = last_idx_q;
    owner_idx_d = owner_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (testMode) begin
          state_d     = ST_TEST;
          grant_d     = '0;
          owner_sel_d = OWNER_TEST;
        end else if (rr_valid_c) begin
          state_d     = ST_OWN;
          grant_d     = rr_onehot_c;
          owner_sel_d = OWNER_W'(rr_idx_c);
          owner_idx_d = rr_idx_c;
          last_idx_d  = rr_idx_c;
          hold_cnt_d  = HOLD_W'(1);
        end
      end

      ST_OWN: begin
        // last_idx already names the owner, so the next pick starts past it.
        if (!owner_req_c || (hold_cnt_q == HOLD_MAX)) begin
          state_d     = ST_DRAIN;
          grant_d     = '0;
          owner_sel_d = OWNER_NONE;
          hold_cnt_d  = '0;
          drain_cnt_d = DRAIN_W'(1);
          last_idx_d  = owner_idx_q;
          if (owner_req_c) begin
            timeout_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_TEST: begin
        if (!testMode) begin
          state_d     = ST_DRAIN;
          grant_d     = '0;
          owner_sel_d = OWNER_NONE;
          drain_cnt_d = DRAIN_W'(1);
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q >= DRAIN_END) begin
          state_d     = ST_IDLE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        owner_sel_d = OWNER_NONE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_sel_q <= OWNER_NONE;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      drain_cnt_q <= '0;
      last_idx_q  <= LAST_RST;
      owner_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_sel_q <= owner_sel_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      last_idx_q  <= last_idx_d;
      owner_idx_q <= owner_idx_d;
    end
  end

  assign grant    = grant_q;
  assign ownerSel = owner_sel_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_lsp_pipe_arbiter.sv
// Bench for lsp_pipe_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural ownership model.
module tb_lsp_pipe_arbiter;

  localparam int NREQ  = 4;
  localparam int DRAIN = 2;
  localparam int MHOLD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       testMode = 1'b0;
  logic [3:0] grant;
  logic [2:0] ownerSel;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lsp_pipe_arbiter #(
    .NUM_REQ      (NREQ),
    .DRAIN_CYCLES (DRAIN),
    .MAX_HOLD     (MHOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .testMode (testMode),
    .grant    (grant),
    .ownerSel (ownerSel),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Model: who owns the pipe (-1 nobody, 0..3 requester, 4 test port),
  // how long they have held it, and how many drain cycles remain.
  int m_owner   = -1;
  int m_held    = 0;
  int m_drain   = 0;
  int m_last    = NREQ - 1;
  int m_timeout = 0;

  always @(posedge clk) begin : model
    if (reset) begin
      m_owner = -1; m_held = 0; m_drain = 0; m_last = NREQ - 1; m_timeout = 0;
    end else if (m_drain > 0) begin
      m_drain = m_drain - 1;
    end else if (m_owner == 4) begin
      if (!testMode) begin m_owner = -1; m_drain = DRAIN; end
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_drain = DRAIN;
      end else if (m_held == MHOLD) begin
        m_owner = -1; m_drain = DRAIN; m_timeout = 1;
      end else begin
        m_held = m_held + 1;
      end
    end else if (testMode) begin
      m_owner = 4;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_last = c; m_held = 1;
        end
      end
    end
  end

  function automatic int exp_grant();
    return (m_owner >= 0 && m_owner < NREQ) ? (1 << m_owner) : 0;
  endfunction

  function automatic int exp_sel();
    return (m_owner < 0) ? 7 : m_owner;
  endfunction

  function automatic int exp_busy();
    return (m_owner >= 0 || m_drain > 0) ? 1 : 0;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("model_grant",   int'(grant),    exp_grant());
      chk("model_sel",     int'(ownerSel), exp_sel());
      chk("model_busy",    int'(busy),     exp_busy());
      chk("model_timeout", int'(timeout),  m_timeout);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    int st_cyc[5];
    int st_own[5];
    int nst;
    int run;
    int cyc;
    int g2;
    logic [3:0] prev;

    // Reset state
    reset = 1'b1; req = 4'b0000; testMode = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel", int'(ownerSel), 7);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    tick();

    // Single requester
    req = 4'b0010; tick();
    chk("single_grant", int'(grant), 2);
    chk("single_sel", int'(ownerSel), 1);
    repeat (4) tick();
    req = 4'b0000; tick();
    chk("single_rel_grant", int'(grant), 0);
    chk("single_rel_busy", int'(busy), 1);
    tick(); tick();
    chk("single_idle_busy", int'(busy), 0);

    // Fairness from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'hF; nst = 0; run = 0; cyc = 0; prev = 4'b0000;
    while (nst < 5 && cyc < 80) begin
      tick(); cyc++;
      if (grant != 4'b0000 && prev == 4'b0000) begin
        st_cyc[nst] = cyc; st_own[nst] = onehot_idx(grant); nst++; run = 0;
      end
      if (grant != 4'b0000) begin
        run++;
        if (run == 3) req = req & ~grant;
      end else begin
        req = 4'hF;
      end
      prev = grant;
    end
    chk("fair_starts", nst, 5);
    for (int i = 0; i < nst; i++) begin
      chk("fair_owner", st_own[i], i % 4);
      if (i > 0) chk("fair_spacing", st_cyc[i] - st_cyc[i-1], 6);
    end
    req = 4'b0000; repeat (8) tick();

    // Timeout: requester 2 never lets go, requester 3 waiting
    req = 4'b1100; tick();
    chk("to_first_grant", int'(grant), 4);
    g2 = 1;
    repeat (7) begin tick(); if (grant == 4'b0100) g2++; end
    chk("to_hold_len", g2, 8);
    tick();
    chk("to_drain_grant", int'(grant), 0);
    chk("to_flag", int'(timeout), 1);
    chk("to_drain_sel", int'(ownerSel), 7);
    tick(); tick();
    chk("to_idle_grant", int'(grant), 0);
    tick();
    chk("to_next_grant", int'(grant), 8);
    chk("to_sticky", int'(timeout), 1);
    req = 4'b0000; repeat (8) tick();

    // Test port beats a simultaneous request
    testMode = 1'b1; req = 4'b0001; tick();
    chk("test_sel", int'(ownerSel), 4);
    chk("test_grant", int'(grant), 0);
    chk("test_busy", int'(busy), 1);
    repeat (3) tick();
    testMode = 1'b0; tick();
    chk("test_drain_sel", int'(ownerSel), 7);
    tick(); tick();
    chk("test_idle_grant", int'(grant), 0);
    tick();
    chk("test_after_grant", int'(grant), 1);
    req = 4'b0000; repeat (6) tick();

    // No preemption by testMode
    req = 4'b0010; tick();
    chk("nopre_sel", int'(ownerSel), 1);
    testMode = 1'b1;
    repeat (3) begin tick(); chk("nopre_hold_sel", int'(ownerSel), 1); end
    req = 4'b0000; tick();
    chk("nopre_drain_sel", int'(ownerSel), 7);
    tick(); tick();
    chk("nopre_idle_sel", int'(ownerSel), 7);
    tick();
    chk("nopre_test_sel", int'(ownerSel), 4);
    testMode = 1'b0; repeat (6) tick();

    // Reset while requester 2 owns
    req = 4'b0100; tick();
    chk("rstown_grant", int'(grant), 4);
    reset = 1'b1; req = 4'b0101; tick();
    chk("rstown_grant0", int'(grant), 0);
    chk("rstown_sel", int'(ownerSel), 7);
    chk("rstown_busy", int'(busy), 0);
    reset = 1'b0; tick();
    chk("rstown_regrant", int'(grant), 1);

    // Random traffic against the model
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 19) == 0) testMode = ~testMode;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
